cache_mem_arb: RTL
==================

Name: cache_mem_arb

Overview:
- Shares one memory-bridge port between the instruction cache (read-only) and the data cache (read + write).
- Uses round-robin arbitration for line reads and keeps one read outstanding at a time. Return beats are routed back to the read owner.
- Holds a one-entry 128-bit write-back buffer for dirty-line evictions. Reads that hit the buffered line are blocked until its write completes.
- Sits between both cache instances and the AXI bridge.

Parameters:
- ADDR_W, 32, byte address width.
- LINE_W, 128, cache-line (write data) width.
- DATA_W, 32, read return beat width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- i_rd_req  in  1  icache line read request
- i_rd_type  in  3  icache read type
- i_rd_addr  in  ADDR_W  icache read address
- i_rd_rdy  out  1  icache request accepted
- i_ret_valid  out  1  icache return beat valid
- i_ret_last  out  1  icache last beat
- i_ret_data  out  DATA_W  icache return data
- d_rd_req  in  1  dcache line read request
- d_rd_type  in  3  dcache read type
- d_rd_addr  in  ADDR_W  dcache read address
- d_rd_rdy  out  1  dcache read accepted
- d_ret_valid  out  1  dcache return beat valid
- d_ret_last  out  1  dcache last beat
- d_ret_data  out  DATA_W  dcache return data
- d_wr_req  in  1  dcache write-back request
- d_wr_type  in  3  write type
- d_wr_addr  in  ADDR_W  write address
- d_wr_wstrb  in  4  write strobe
- d_wr_data  in  LINE_W  write-back line
- d_wr_rdy  out  1  write buffer free
- m_rd_req  out  1  bridge read request
- m_rd_type  out  3  bridge read type
- m_rd_addr  out  ADDR_W  bridge read address
- m_rd_rdy  in  1  bridge accepted read
- m_ret_valid  in  1  bridge return beat valid
- m_ret_last  in  1  bridge last beat
- m_ret_data  in  DATA_W  bridge return data
- m_wr_req  out  1  bridge write request
- m_wr_type  out  3  write type
- m_wr_addr  out  ADDR_W  write address
- m_wr_wstrb  out  4  write strobe
- m_wr_data  out  LINE_W  write data
- m_wr_rdy  in  1  bridge accepted write
- m_wr_done  in  1  single-cycle pulse when the write response returns

Behaviour:
- Reset: asynchronous, active-high.
  - Both FSMs return to their idle state and last_grant=1 (dcache), so the first tie goes to icache.
  - All outputs are 0, except d_wr_rdy=1.
  - A bridge transaction in flight at reset is abandoned; the bridge is reset together with this block.
- Read FSM states: R_IDLE, R_REQ, R_RESP.
  - R_IDLE, requester eligibility: a requester is eligible if its rd_req=1 and it is not blocked.
  - R_IDLE, blocking rule: a requester is blocked when the write FSM is not in W_IDLE and its rd_addr[31:4] equals the buffered wr_addr[31:4].
  - R_IDLE, winner selection: if both requesters are eligible, the winner is the one not equal to last_grant.
  - R_IDLE, grant cycle: the winner's rd_rdy=1 combinationally in the grant cycle. The arbiter then latches addr, type, owner and last_grant, and moves to R_REQ.
  - R_REQ: m_rd_req=1 with the latched addr/type until m_rd_rdy=1, then go to R_RESP.
  - R_RESP: m_ret_data is broadcast to both i_ret_data and d_ret_data. Only the owner's ret_valid and ret_last mirror m_ret_valid and m_ret_last. On m_ret_valid & m_ret_last, go to R_IDLE.
  - Grant-to-first-beat latency is at least 2 cycles. No new grant is issued before the last beat.
  - rd_rdy is 0 in R_REQ and R_RESP.
  - In R_IDLE, a m_ret_valid with no owner is ignored.
- Write FSM states: W_IDLE, W_REQ, W_WAIT.
  - d_wr_rdy = (state==W_IDLE).
  - W_IDLE: on d_wr_req & d_wr_rdy, latch all write fields and go to W_REQ.
  - W_REQ: m_wr_req=1 until m_wr_rdy=1, then go to W_WAIT.
  - W_WAIT: on m_wr_done, go to W_IDLE.
  - An m_wr_done arriving in any other state is ignored.
- Simultaneous events:
  - A write latch and a read grant in the same cycle are allowed; the hazard compare uses the already-registered buffer only.
  - Consequence: a same-line read issued in the cycle the write is latched is granted. The dcache never does this, because it issues the write-back before the refill.
  - Read and write channels proceed independently on the bridge.
- Request signals must be held until their rdy; the arbiter does not buffer dropped requests.

Decomposition:
- Shared package cache_pkg holds the following, reused by the caches:
  - State encodings: R_IDLE/R_REQ/R_RESP as one-hot 3-bit; W_IDLE/W_REQ/W_WAIT as one-hot 3-bit.
  - OWNER_I=0, OWNER_D=1.
  - LINE_TYPE=3'b100.
- Sub-module: rr_arb2, a two-input round-robin grant with a last_grant register.
- The write buffer stays inline.

Test Plan:
- Lone icache read: i_rd_req, addr 0x1C00_0040; bridge returns 4 beats 0x11..0x44 -> i_rd_rdy pulse; m_rd_addr=0x1C00_0040; four i_ret_valid beats with i_ret_last on 0x44; d_ret_valid stays 0.
- Tie: i_rd_req and d_rd_req raised in the same cycle after reset -> icache granted first. After its last beat, dcache is granted. A second tie then grants icache again.
- Write-back: d_wr_req, addr 0x0000_1230, data 128'h…; m_wr_rdy delayed 3 cycles -> m_wr_req held 3 cycles; d_wr_rdy=0 until the m_wr_done pulse, then 1.
- Hazard: write buffered to line 0x0000_1230; d_rd_req for 0x0000_1230 -> no d_rd_rdy until the cycle after m_wr_done. d_rd_req for 0x0000_2230 instead -> granted immediately.
- Reset mid-read: assert reset during R_RESP beat 2 -> all outputs 0 asynchronously, d_wr_rdy=1. After release, a new i_rd_req is granted normally.
- Stray beat: m_ret_valid with the read FSM in R_IDLE -> neither ret_valid asserted; FSM stays in R_IDLE.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared cache/memory-port definitions: FSM encodings, requester ids, request types.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cache_pkg;

    // One-hot read-channel states of the memory arbiter.
    typedef enum logic [2:0] {
        R_IDLE = 3'b001,
        R_REQ  = 3'b010,
        R_RESP = 3'b100
    } rd_state_t;

    // One-hot write-back buffer states.
    typedef enum logic [2:0] {
        W_IDLE = 3'b001,
        W_REQ  = 3'b010,
        W_WAIT = 3'b100
    } wr_state_t;

    // Requester ids; also the bit position of each requester in arbiter vectors.
    localparam logic OWNER_I = 1'b0;
    localparam logic OWNER_D = 1'b1;

    // Full cache-line transfer.
    localparam logic [2:0] LINE_TYPE = 3'b100;

    // Byte-offset bits inside one 16-byte line; above these is the line tag.
    localparam int LINE_OFS_W = 4;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; on a tie the requester not granted last time wins.
// Latency: grant is combinational from req; the fairness pointer updates on the next edge.
// Backpressure: en=0 suppresses all grants and freezes the pointer.
//
// Ports:
//   clk, reset     clock, asynchronous active-high reset (pointer -> OWNER_D)
//   req[1:0]       bit OWNER_I = icache, bit OWNER_D = dcache
//   en             arbitration allowed this cycle
//   gnt[1:0]       one-hot grant (zero when nothing granted)
//   gnt_id         id of the granted requester (only meaningful when |gnt)
module rr_arb2
    import cache_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt,
    output logic       gnt_id
);

    logic last_grant;

    always_comb begin
        gnt    = 2'b00;
        gnt_id = OWNER_I;
        if (req[OWNER_I] && req[OWNER_D]) begin
            gnt_id = ~last_grant;
        end else if (req[OWNER_D]) begin
            gnt_id = OWNER_D;
        end
        if (en && (|req)) begin
            gnt = (gnt_id == OWNER_D) ? 2'b10 : 2'b01;
        end
    end

    // Starts at OWNER_D so the first tie after reset goes to the icache.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant <= OWNER_D;
        end else if (en && (|req)) begin
            last_grant <= gnt_id;
        end
    end

endmodule

// File: rtl/cache_mem_arb.sv
// Shares one bridge port between icache (line reads) and dcache (line reads + write-backs).
// Latency: read grant is combinational; bridge request the cycle after grant; write latched in one cycle.
// Backpressure: one read outstanding; one-entry write buffer (d_wr_rdy=0 while occupied); reads to the buffered line wait.
//
// Ports:
//   clk, reset                     clock, asynchronous active-high reset
//   i_rd_* / i_ret_*               icache read request and return beats
//   d_rd_* / d_ret_*               dcache read request and return beats
//   d_wr_*                         dcache dirty-line write-back into the buffer
//   m_rd_* / m_ret_*               bridge read channel
//   m_wr_* / m_wr_done             bridge write channel and write-response pulse
module cache_mem_arb
    import cache_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 128,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_rd_req,
    input  logic [2:0]        i_rd_type,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic              i_rd_rdy,
    output logic              i_ret_valid,
    output logic              i_ret_last,
    output logic [DATA_W-1:0] i_ret_data,
    input  logic              d_rd_req,
    input  logic [2:0]        d_rd_type,
    input  logic [ADDR_W-1:0] d_rd_addr,
    output logic              d_rd_rdy,
    output logic              d_ret_valid,
    output logic              d_ret_last,
    output logic [DATA_W-1:0] d_ret_data,
    input  logic              d_wr_req,
    input  logic [2:0]        d_wr_type,
    input  logic [ADDR_W-1:0] d_wr_addr,
    input  logic [3:0]        d_wr_wstrb,
    input  logic [LINE_W-1:0] d_wr_data,
    output logic              d_wr_rdy,
    output logic              m_rd_req,
    output logic [2:0]        m_rd_type,
    output logic [ADDR_W-1:0] m_rd_addr,
    input  logic              m_rd_rdy,
    input  logic              m_ret_valid,
    input  logic              m_ret_last,
    input  logic [DATA_W-1:0] m_ret_data,
    output logic              m_wr_req,
    output logic [2:0]        m_wr_type,
    output logic [ADDR_W-1:0] m_wr_addr,
    output logic [3:0]        m_wr_wstrb,
    output logic [LINE_W-1:0] m_wr_data,
    input  logic              m_wr_rdy,
    input  logic              m_wr_done
);

    rd_state_t         rd_state;
    wr_state_t         wr_state;
    logic              rd_owner;
    logic [ADDR_W-1:0] rd_addr_q;
    logic [2:0]        rd_type_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [2:0]        wr_type_q;
    logic [3:0]        wr_strb_q;
    logic [LINE_W-1:0] wr_data_q;

    logic              wr_busy;
    logic              i_blk;
    logic              d_blk;
    logic [1:0]        rd_elig;
    logic              arb_en;
    logic [1:0]        rd_gnt;
    logic              gnt_id;
    logic              rd_resp;

    // Hazard check looks only at the registered buffer, so a write being
    // latched this very cycle does not block a same-line read yet.
    assign wr_busy = (wr_state != W_IDLE);
    assign i_blk   = wr_busy && (i_rd_addr[ADDR_W-1:LINE_OFS_W] == wr_addr_q[ADDR_W-1:LINE_OFS_W]);
    assign d_blk   = wr_busy && (d_rd_addr[ADDR_W-1:LINE_OFS_W] == wr_addr_q[ADDR_W-1:LINE_OFS_W]);

    assign rd_elig[OWNER_I] = i_rd_req && !i_blk;
    assign rd_elig[OWNER_D] = d_rd_req && !d_blk;

    // Gating on reset keeps rd_rdy low while reset is held.
    assign arb_en = (rd_state == R_IDLE) && !reset;

    rr_arb2 u_arb (
        .clk    (clk),
        .reset  (reset),
        .req    (rd_elig),
        .en     (arb_en),
        .gnt    (rd_gnt),
        .gnt_id (gnt_id)
    );

    assign i_rd_rdy = rd_gnt[OWNER_I];
    assign d_rd_rdy = rd_gnt[OWNER_D];

    // Read channel
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_state  <= R_IDLE;
            rd_owner  <= OWNER_I;
            rd_addr_q <= '0;
            rd_type_q <= '0;
        end else begin
            case (rd_state)
                R_IDLE: begin
                    if (|rd_gnt) begin
                        rd_owner  <= gnt_id;
                        rd_addr_q <= (gnt_id == OWNER_D) ? d_rd_addr : i_rd_addr;
                        rd_type_q <= (gnt_id == OWNER_D) ? d_rd_type : i_rd_type;
                        rd_state  <= R_REQ;
                    end
                end
                R_REQ: begin
                    if (m_rd_rdy) begin
                        rd_state <= R_RESP;
                    end
                end
                R_RESP: begin
                    if (m_ret_valid && m_ret_last) begin
                        rd_state <= R_IDLE;
                    end
                end
                default: rd_state <= R_IDLE;
            endcase
        end
    end

    assign m_rd_req  = (rd_state == R_REQ);
    assign m_rd_addr = rd_addr_q;
    assign m_rd_type = rd_type_q;

    // Beats outside R_RESP have no owner and are dropped; data is zeroed there
    // so nothing leaks to either cache while idle or in reset.
    assign rd_resp     = (rd_state == R_RESP);
    assign i_ret_valid = rd_resp && (rd_owner == OWNER_I) && m_ret_valid;
    assign i_ret_last  = rd_resp && (rd_owner == OWNER_I) && m_ret_last;
    assign d_ret_valid = rd_resp && (rd_owner == OWNER_D) && m_ret_valid;
    assign d_ret_last  = rd_resp && (rd_owner == OWNER_D) && m_ret_last;
    assign i_ret_data  = rd_resp ? m_ret_data : '0;
    assign d_ret_data  = rd_resp ? m_ret_data : '0;

    // Write-back buffer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_state  <= W_IDLE;
            wr_addr_q <= '0;
            wr_type_q <= '0;
            wr_strb_q <= '0;
            wr_data_q <= '0;
        end else begin
            case (wr_state)
                W_IDLE: begin
                    if (d_wr_req) begin
                        wr_addr_q <= d_wr_addr;
                        wr_type_q <= d_wr_type;
                        wr_strb_q <= d_wr_wstrb;
                        wr_data_q <= d_wr_data;
                        wr_state  <= W_REQ;
                    end
                end
                W_REQ: begin
                    if (m_wr_rdy) begin
                        wr_state <= W_WAIT;
                    end
                end
                W_WAIT: begin
                    if (m_wr_done) begin
                        wr_state <= W_IDLE;
                    end
                end
                default: wr_state <= W_IDLE;
            endcase
        end
    end

    assign d_wr_rdy   = (wr_state == W_IDLE);
    assign m_wr_req   = (wr_state == W_REQ);
    assign m_wr_addr  = wr_addr_q;
    assign m_wr_type  = wr_type_q;
    assign m_wr_wstrb = wr_strb_q;
    assign m_wr_data  = wr_data_q;

endmodule
